// File: rtl/seg7_pkg.sv
// Shared types, constants and helper functions for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    SCAN_SHOW  = 1'b0,
    SCAN_BLANK = 1'b1
  } scan_state_t;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  // Active-low segment pattern for a hex nibble, bit6=g ... bit0=a.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Active-low one-cold anode enable for a digit index.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_write_arb.sv
// Two-requester round-robin write arbiter for the digit registers.
// The pointer only moves on contention, so it always names the winner of the next tie.
module seg7_write_arb
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [1:0] a_addr,
  input  logic [3:0] a_data,
  input  logic       b_valid,
  input  logic [1:0] b_addr,
  input  logic [3:0] b_data,
  output logic       a_ready,
  output logic       b_ready,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [3:0] wr_data
);

  logic prio_b;

  // Grant decode: sole requester wins, ties go to the pointer; nothing granted in reset.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst_n) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end else if (a_valid && b_valid) begin
      a_ready = ~prio_b;
      b_ready = prio_b;
    end else begin
      a_ready = a_valid;
      b_ready = b_valid;
    end
  end

  // Winning write steering toward the digit registers.
  always_comb begin
    wr_en   = a_ready | b_ready;
    wr_addr = 2'd0;
    wr_data = 4'd0;
    if (b_ready) begin
      wr_addr = b_addr;
      wr_data = b_data;
    end else begin
      wr_addr = a_addr;
      wr_data = a_data;
    end
  end

  // Round-robin pointer flips whenever both requesters compete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b <= 1'b0;
    end else if (a_valid && b_valid) begin
      prio_b <= ~prio_b;
    end else begin
      prio_b <= prio_b;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode display scanner with blanking gaps and an arbitrated
// write port to the digit registers. Display outputs are registered and lag
// the scan state by one cycle.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned TERM  = 216666,
  parameter int unsigned BLANK = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Enable,
  input  logic       A_Valid,
  input  logic [1:0] A_Addr,
  input  logic [3:0] A_Data,
  output logic       A_Ready,
  input  logic       B_Valid,
  input  logic [1:0] B_Addr,
  input  logic [3:0] B_Data,
  output logic       B_Ready,
  output logic [3:0] Anode,
  output logic [6:0] Cathodes,
  output logic [1:0] Digit,
  output logic       FrameTick
);

  localparam logic [27:0] TERM_LAST  = 28'(TERM);
  localparam logic [27:0] BLANK_LAST = 28'(BLANK - 1);

  scan_state_t state;
  logic [27:0] count;
  logic [1:0]  digit;
  logic [3:0]  digit_regs [4];
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [3:0]  wr_data;

  assign Digit = digit;

  seg7_write_arb u_arb (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .a_valid (A_Valid),
    .a_addr  (A_Addr),
    .a_data  (A_Data),
    .b_valid (B_Valid),
    .b_addr  (B_Addr),
    .b_data  (B_Data),
    .a_ready (A_Ready),
    .b_ready (B_Ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Scan FSM: dwell on each digit, then a blank gap, advancing the digit after the gap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= SCAN_SHOW;
      count     <= 28'd0;
      digit     <= 2'd0;
      FrameTick <= 1'b0;
    end else if (!Enable) begin
      state     <= SCAN_SHOW;
      count     <= 28'd0;
      digit     <= 2'd0;
      FrameTick <= 1'b0;
    end else begin
      FrameTick <= 1'b0;
      case (state)
        SCAN_SHOW: begin
          if (count == TERM_LAST) begin
            count <= 28'd0;
            state <= SCAN_BLANK;
          end else begin
            count <= count + 28'd1;
          end
        end
        SCAN_BLANK: begin
          if (count == BLANK_LAST) begin
            count     <= 28'd0;
            digit     <= digit + 2'd1;
            state     <= SCAN_SHOW;
            FrameTick <= (digit == 2'd3);
          end else begin
            count <= count + 28'd1;
          end
        end
        default: begin
          state <= SCAN_SHOW;
          count <= 28'd0;
        end
      endcase
    end
  end

  // Digit register file, written by the arbiter winner.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) begin
        digit_regs[i] <= 4'd0;
      end
    end else if (wr_en) begin
      digit_regs[wr_addr] <= wr_data;
    end else begin
      digit_regs <= digit_regs;
    end
  end

  // Registered display drive: lit digit while showing, everything off otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Anode    <= ANODE_OFF;
      Cathodes <= SEG_OFF;
    end else if (Enable && (state == SCAN_SHOW)) begin
      Anode    <= anode_sel(digit);
      Cathodes <= hex2seg(digit_regs[digit]);
    end else begin
      Anode    <= ANODE_OFF;
      Cathodes <= SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with TERM=9, BLANK=2
// (10 lit cycles + 2 blank cycles per digit, 48-cycle frame).
module tb_seg7_scan_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Enable = 1'b1;
  logic       A_Valid = 1'b0;
  logic [1:0] A_Addr = 2'd0;
  logic [3:0] A_Data = 4'd0;
  logic       A_Ready;
  logic       B_Valid = 1'b0;
  logic [1:0] B_Addr = 2'd0;
  logic [3:0] B_Data = 4'd0;
  logic       B_Ready;
  logic [3:0] Anode;
  logic [6:0] Cathodes;
  logic [1:0] Digit;
  logic       FrameTick;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic found;

  logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_ctrl #(.TERM(9), .BLANK(2)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Enable    (Enable),
    .A_Valid   (A_Valid),
    .A_Addr    (A_Addr),
    .A_Data    (A_Data),
    .A_Ready   (A_Ready),
    .B_Valid   (B_Valid),
    .B_Addr    (B_Addr),
    .B_Data    (B_Data),
    .B_Ready   (B_Ready),
    .Anode     (Anode),
    .Cathodes  (Cathodes),
    .Digit     (Digit),
    .FrameTick (FrameTick)
  );

  always #5 Clk = ~Clk;

  // Reset for three cycles and release on a falling edge (no rising edge seen yet).
  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    Enable  = 1'b1;
    A_Valid = 1'b0;
    B_Valid = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Wait (bounded) until the given anode pattern is driven.
  task automatic wait_anode(input logic [3:0] a);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge Clk);
      if (Anode === a) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    Enable  = 1'b1;
    repeat (2) @(negedge Clk);
    total_cnt++;
    if (Anode !== 4'b1111 || Cathodes !== 7'b1111111) $display("FAIL reset_outputs: got %b/%b expected 1111/1111111", Anode, Cathodes);
    else pass_cnt++;
    total_cnt++;
    if (Digit !== 2'd0 || FrameTick !== 1'b0 || A_Ready !== 1'b0 || B_Ready !== 1'b0) $display("FAIL reset_misc: got digit=%0d ft=%b ar=%b br=%b expected 0 0 0 0", Digit, FrameTick, A_Ready, B_Ready);
    else pass_cnt++;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    total_cnt++;
    if (Anode !== 4'b1110 || Cathodes !== 7'b1000000) $display("FAIL reset_first_lit: got %b/%b expected 1110/1000000", Anode, Cathodes);
    else pass_cnt++;
  endtask

  task automatic test_scan_timing();
    int c, d;
    logic [3:0] exp_an;
    logic exp_ft;
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      @(negedge Clk);
      c = n - 1;
      d = (c / 12) % 4;
      exp_an = ((c % 12) < 10) ? ~(4'b0001 << d) : 4'b1111;
      exp_ft = ((n % 48) == 0);
      total_cnt++;
      if (Anode !== exp_an) $display("FAIL scan_anode[%0d]: got %b expected %b", n, Anode, exp_an);
      else pass_cnt++;
      total_cnt++;
      if (FrameTick !== exp_ft) $display("FAIL scan_frametick[%0d]: got %b expected %b", n, FrameTick, exp_ft);
      else pass_cnt++;
      total_cnt++;
      if (Digit !== 2'((n / 12) % 4)) $display("FAIL scan_digit[%0d]: got %0d expected %0d", n, Digit, (n / 12) % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_path();
    do_reset();
    repeat (26) @(negedge Clk);
    A_Valid = 1'b1; A_Addr = 2'd2; A_Data = 4'd4;
    #1;
    total_cnt++;
    if (A_Ready !== 1'b1 || B_Ready !== 1'b0) $display("FAIL write_ready: got ar=%b br=%b expected 1 0", A_Ready, B_Ready);
    else pass_cnt++;
    @(negedge Clk);
    A_Valid = 1'b0;
    total_cnt++;
    if (Cathodes !== 7'b1000000 || Anode !== 4'b1011) $display("FAIL write_lag: got %b/%b expected 1011/1000000", Anode, Cathodes);
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if (Cathodes !== 7'b0011001 || Anode !== 4'b1011) $display("FAIL write_visible: got %b/%b expected 1011/0011001", Anode, Cathodes);
    else pass_cnt++;
  endtask

  task automatic test_hex_table();
    do_reset();
    for (int v = 0; v < 16; v++) begin
      @(negedge Clk);
      B_Valid = 1'b1; B_Addr = 2'd0; B_Data = 4'(v);
      #1;
      total_cnt++;
      if (B_Ready !== 1'b1 || A_Ready !== 1'b0) $display("FAIL hex_ready[%0d]: got br=%b ar=%b expected 1 0", v, B_Ready, A_Ready);
      else pass_cnt++;
      @(negedge Clk);
      B_Valid = 1'b0;
      @(negedge Clk);
      wait_anode(4'b1110);
      total_cnt++;
      if (found !== 1'b1 || Cathodes !== seg_tbl[v]) $display("FAIL hex_seg[%0d]: got found=%b seg=%b expected 1 %b", v, found, Cathodes, seg_tbl[v]);
      else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge Clk);
    A_Valid = 1'b1; A_Addr = 2'd1; A_Data = 4'd3;
    B_Valid = 1'b1; B_Addr = 2'd1; B_Data = 4'd2;
    #1;
    total_cnt++;
    if (A_Ready !== 1'b1 || B_Ready !== 1'b0) $display("FAIL contend1_first: got ar=%b br=%b expected 1 0", A_Ready, B_Ready);
    else pass_cnt++;
    @(negedge Clk);
    A_Valid = 1'b0;
    #1;
    total_cnt++;
    if (A_Ready !== 1'b0 || B_Ready !== 1'b1) $display("FAIL contend1_second: got ar=%b br=%b expected 0 1", A_Ready, B_Ready);
    else pass_cnt++;
    @(negedge Clk);
    B_Valid = 1'b0;
    @(negedge Clk);
    wait_anode(4'b1101);
    total_cnt++;
    if (found !== 1'b1 || Cathodes !== 7'b0100100) $display("FAIL contend1_value: got found=%b seg=%b expected 1 0100100", found, Cathodes);
    else pass_cnt++;
    A_Valid = 1'b1; A_Addr = 2'd0; A_Data = 4'd5;
    B_Valid = 1'b1; B_Addr = 2'd0; B_Data = 4'd6;
    #1;
    total_cnt++;
    if (A_Ready !== 1'b0 || B_Ready !== 1'b1) $display("FAIL contend2_first: got ar=%b br=%b expected 0 1", A_Ready, B_Ready);
    else pass_cnt++;
    @(negedge Clk);
    B_Valid = 1'b0;
    #1;
    total_cnt++;
    if (A_Ready !== 1'b1 || B_Ready !== 1'b0) $display("FAIL contend2_second: got ar=%b br=%b expected 1 0", A_Ready, B_Ready);
    else pass_cnt++;
    @(negedge Clk);
    A_Valid = 1'b0;
    @(negedge Clk);
    wait_anode(4'b1110);
    total_cnt++;
    if (found !== 1'b1 || Cathodes !== 7'b0010010) $display("FAIL contend2_value: got found=%b seg=%b expected 1 0010010", found, Cathodes);
    else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    do_reset();
    repeat (38) @(negedge Clk);
    total_cnt++;
    if (Anode !== 4'b0111) $display("FAIL en_pre: got %b expected 0111", Anode);
    else pass_cnt++;
    Enable = 1'b0;
    @(negedge Clk);
    total_cnt++;
    if (Anode !== 4'b1111 || Cathodes !== 7'b1111111 || Digit !== 2'd0) $display("FAIL en_off: got %b/%b digit=%0d expected 1111/1111111 digit=0", Anode, Cathodes, Digit);
    else pass_cnt++;
    repeat (3) @(negedge Clk);
    total_cnt++;
    if (Anode !== 4'b1111 || Digit !== 2'd0) $display("FAIL en_parked: got %b digit=%0d expected 1111 digit=0", Anode, Digit);
    else pass_cnt++;
    Enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      total_cnt++;
      if (Anode !== 4'b1110 || Cathodes !== 7'b1000000) $display("FAIL en_dwell[%0d]: got %b/%b expected 1110/1000000", i, Anode, Cathodes);
      else pass_cnt++;
    end
    @(negedge Clk);
    total_cnt++;
    if (Anode !== 4'b1111) $display("FAIL en_dwell_end: got %b expected 1111", Anode);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_blank();
    do_reset();
    @(negedge Clk);
    A_Valid = 1'b1; A_Addr = 2'd0; A_Data = 4'd8;
    @(negedge Clk);
    A_Valid = 1'b0;
    @(negedge Clk);
    total_cnt++;
    if (Anode !== 4'b1110 || Cathodes !== 7'b0000000) $display("FAIL rst_pre_value: got %b/%b expected 1110/0000000", Anode, Cathodes);
    else pass_cnt++;
    repeat (8) @(negedge Clk);
    total_cnt++;
    if (Anode !== 4'b1111) $display("FAIL rst_in_blank: got %b expected 1111", Anode);
    else pass_cnt++;
    A_Valid = 1'b1; A_Addr = 2'd3; A_Data = 4'd7;
    #1;
    Reset_n = 1'b0;
    #1;
    total_cnt++;
    if (Anode !== 4'b1111 || Cathodes !== 7'b1111111 || Digit !== 2'd0 || A_Ready !== 1'b0) $display("FAIL rst_async: got %b/%b digit=%0d ar=%b expected 1111/1111111 0 0", Anode, Cathodes, Digit, A_Ready);
    else pass_cnt++;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    total_cnt++;
    if (A_Ready !== 1'b1) $display("FAIL rst_regrant: got %b expected 1", A_Ready);
    else pass_cnt++;
    @(negedge Clk);
    A_Valid = 1'b0;
    @(negedge Clk);
    wait_anode(4'b1110);
    total_cnt++;
    if (found !== 1'b1 || Cathodes !== 7'b1000000) $display("FAIL rst_cleared: got found=%b seg=%b expected 1 1000000", found, Cathodes);
    else pass_cnt++;
    wait_anode(4'b0111);
    total_cnt++;
    if (found !== 1'b1 || Cathodes !== 7'b1111000) $display("FAIL rst_retry_value: got found=%b seg=%b expected 1 1111000", found, Cathodes);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_write_path();
    test_hex_table();
    test_contention();
    test_enable_drop();
    test_reset_mid_blank();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
